dwt_line_sequencer: RTL

- Framing controller in front of the 1D DWT processing unit (row or column filter).
- Accepts an untagged stream of {odd, even} sample pairs and a runtime frame size.
- Tags pairs with sof/eol from internal column/row counters and forwards them over a ready/valid handshake.
- Reports busy/done so the tile scheduler can sequence frames back-to-back.

---
 rtl/dwt_line_sequencer.sv | 192 +++++++++++++++++++
 1 files changed

// File: rtl/dwt_line_sequencer.sv
// Framing controller ahead of the 1D DWT unit: tags sof/eol on pair stream.
// Optional: define DWT_SEQ_FLUSH_EN to append FlushPairs zero pairs per line.
module dwt_line_sequencer #(
    parameter int DataWidth       = 16,
    parameter int MaximumSideSize = 512,
    parameter int FlushPairs      = 2
) (
    input  logic                                   clk_i,
    input  logic                                   rst_i,
    input  logic [$clog2(MaximumSideSize/2):0]     cfg_width_i,
    input  logic [$clog2(MaximumSideSize):0]       cfg_height_i,
    input  logic                                   start_i,
    output logic                                   busy_o,
    output logic                                   done_o,
    output logic                                   cfg_err_o,
    output logic                                   s_ready_o,
    input  logic                                   s_valid_i,
    input  logic [2*DataWidth-1:0]                 s_data_i,
    input  logic                                   m_ready_i,
    output logic                                   m_valid_o,
    output logic                                   m_sof_o,
    output logic                                   m_eol_o,
    output logic [2*DataWidth-1:0]                 m_data_o
);
    localparam int WW = $clog2(MaximumSideSize/2) + 1;
    localparam int HW = $clog2(MaximumSideSize) + 1;
    localparam int PW = 2 * DataWidth;
    localparam logic [WW-1:0] MaxW = WW'(MaximumSideSize/2);
    localparam logic [HW-1:0] MaxH = HW'(MaximumSideSize);

    if (FlushPairs < 1 || FlushPairs > 4) begin : g_bad_flush
        $error("FlushPairs must be in 1..4");
    end

`ifdef DWT_SEQ_FLUSH_EN
    localparam int FW = $clog2(FlushPairs + 1);
    localparam logic [FW-1:0] FlushLast = FW'(FlushPairs - 1);
    typedef enum logic [1:0] {IDLE, RUN, FLUSH, DRAIN} state_t;
    logic [FW-1:0] flush_q, flush_d;
`else
    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;
`endif

    state_t        state_q, state_d;
    logic [WW-1:0] width_q, width_d;
    logic [HW-1:0] height_q, height_d;
    logic [WW-1:0] col_q, col_d;
    logic [HW-1:0] row_q, row_d;
    logic          m_valid_q, m_valid_d;
    logic          m_sof_q, m_sof_d;
    logic          m_eol_q, m_eol_d;
    logic [PW-1:0] m_data_q, m_data_d;
    logic          cfg_err_q, cfg_err_d;
    logic          out_free, last_col, last_row, bad_cfg;
    logic          s_ready, done;

    // Next-state, counters, output register and handshake control
    always_comb begin
        state_d   = state_q;
        width_d   = width_q;
        height_d  = height_q;
        col_d     = col_q;
        row_d     = row_q;
        m_valid_d = m_valid_q;
        m_sof_d   = m_sof_q;
        m_eol_d   = m_eol_q;
        m_data_d  = m_data_q;
        cfg_err_d = 1'b0;
        s_ready   = 1'b0;
        done      = 1'b0;
`ifdef DWT_SEQ_FLUSH_EN
        flush_d   = flush_q;
`endif
        out_free = !m_valid_q || m_ready_i;
        last_col = (col_q == width_q - 1'b1);
        last_row = (row_q == height_q - 1'b1);
        bad_cfg  = (cfg_width_i == '0) || (cfg_width_i > MaxW) ||
                   (cfg_height_i == '0) || (cfg_height_i > MaxH);
        if (m_valid_q && m_ready_i) begin
            m_valid_d = 1'b0;
        end
        unique case (state_q)
            IDLE: begin
                if (start_i) begin
                    if (bad_cfg) begin
                        cfg_err_d = 1'b1;
                    end else begin
                        width_d  = cfg_width_i;
                        height_d = cfg_height_i;
                        col_d    = '0;
                        row_d    = '0;
                        state_d  = RUN;
                    end
                end
            end
            RUN: begin
                s_ready = out_free;
                if (s_valid_i && out_free) begin
                    m_valid_d = 1'b1;
                    m_data_d  = s_data_i;
                    m_sof_d   = (col_q == '0) && (row_q == '0);
                    m_eol_d   = 1'b0;
                    if (last_col) begin
                        col_d = '0;
`ifdef DWT_SEQ_FLUSH_EN
                        flush_d = '0;
                        state_d = FLUSH;
`else
                        m_eol_d = 1'b1;
                        if (last_row) begin
                            state_d = DRAIN;
                        end else begin
                            row_d = row_q + 1'b1;
                        end
`endif
                    end else begin
                        col_d = col_q + 1'b1;
                    end
                end
            end
`ifdef DWT_SEQ_FLUSH_EN
            FLUSH: begin
                if (out_free) begin
                    m_valid_d = 1'b1;
                    m_data_d  = '0;
                    m_sof_d   = 1'b0;
                    m_eol_d   = (flush_q == FlushLast);
                    if (flush_q == FlushLast) begin
                        if (last_row) begin
                            state_d = DRAIN;
                        end else begin
                            row_d   = row_q + 1'b1;
                            state_d = RUN;
                        end
                    end else begin
                        flush_d = flush_q + 1'b1;
                    end
                end
            end
`endif
            DRAIN: begin
                if (m_valid_q && m_ready_i) begin
                    done    = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers with synchronous reset
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= IDLE;
            width_q   <= '0;
            height_q  <= '0;
            col_q     <= '0;
            row_q     <= '0;
            m_valid_q <= 1'b0;
            m_sof_q   <= 1'b0;
            m_eol_q   <= 1'b0;
            m_data_q  <= '0;
            cfg_err_q <= 1'b0;
`ifdef DWT_SEQ_FLUSH_EN
            flush_q   <= '0;
`endif
        end else begin
            state_q   <= state_d;
            width_q   <= width_d;
            height_q  <= height_d;
            col_q     <= col_d;
            row_q     <= row_d;
            m_valid_q <= m_valid_d;
            m_sof_q   <= m_sof_d;
            m_eol_q   <= m_eol_d;
            m_data_q  <= m_data_d;
            cfg_err_q <= cfg_err_d;
`ifdef DWT_SEQ_FLUSH_EN
            flush_q   <= flush_d;
`endif
        end
    end

    assign busy_o    = (state_q != IDLE);
    assign done_o    = done;
    assign cfg_err_o = cfg_err_q;
    assign s_ready_o = s_ready;
    assign m_valid_o = m_valid_q;
    assign m_sof_o   = m_sof_q;
    assign m_eol_o   = m_eol_q;
    assign m_data_o  = m_data_q;
endmodule
